givens_rot_pipe: RTL and testbench

GIVENS_ROT_PIPE -- requirements
Module: givens_rot_pipe

---
 rtl/givens_rot_pipe.sv | 118 +++++++++++
 tb/tb_givens_rot_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/givens_rot_pipe.sv
// Two-stage Givens rotation pipeline: (x, y) -> (c*x + s*y, c*y - s*x) in fixed point.
// One (c, s) pair per row of ROW_LEN elements, latched on the row's first element.
module givens_rot_pipe #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned FRAC       = 16,
    parameter int unsigned ROW_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_c,
    input  logic [DATA_WIDTH-1:0] in_s,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_last
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ROW_LEN - 1);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_last;
    logic                 s1_load;
    logic                 s2_load;
    logic                 accept;
    logic [CW-1:0]        cnt;
    logic signed [DW-1:0] c_reg;
    logic signed [DW-1:0] s_reg;
    logic signed [DW-1:0] c_use;
    logic signed [DW-1:0] s_use;
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] y_in;
    logic signed [PW-1:0] p_cx;
    logic signed [PW-1:0] p_sy;
    logic signed [PW-1:0] p_cy;
    logic signed [PW-1:0] p_sx;
    logic [DW-1:0]        t_cx;
    logic [DW-1:0]        t_sy;
    logic [DW-1:0]        t_cy;
    logic [DW-1:0]        t_sx;

    // Skid-free handshake: a stage advances when its successor frees up this cycle
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign accept    = in_valid && s1_load;
    assign out_valid = s2_valid;

    // First element of a row uses the live coefficients; the rest use the latched copy
    assign c_use = (cnt == '0) ? $signed(in_c) : c_reg;
    assign s_use = (cnt == '0) ? $signed(in_s) : s_reg;
    assign x_in  = $signed(in_x);
    assign y_in  = $signed(in_y);

    assign t_cx = p_cx[FRAC+DW-1:FRAC];
    assign t_sy = p_sy[FRAC+DW-1:FRAC];
    assign t_cy = p_cy[FRAC+DW-1:FRAC];
    assign t_sx = p_sx[FRAC+DW-1:FRAC];

    // S1: full-width products, element counter and coefficient latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            cnt      <= '0;
            c_reg    <= '0;
            s_reg    <= '0;
            p_cx     <= '0;
            p_sy     <= '0;
            p_cy     <= '0;
            p_sx     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    p_cx    <= PW'(c_use) * PW'(x_in);
                    p_sy    <= PW'(s_use) * PW'(y_in);
                    p_cy    <= PW'(c_use) * PW'(y_in);
                    p_sx    <= PW'(s_use) * PW'(x_in);
                    s1_last <= (cnt == CNT_LAST);
                end
            end
            if (accept) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                if (cnt == '0) begin
                    c_reg <= $signed(in_c);
                    s_reg <= $signed(in_s);
                end
            end
        end
    end

    // S2: truncated sums, wrapping; held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
            out_last <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_x    <= t_cx + t_sy;
                out_y    <= t_cy - t_sx;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_givens_rot_pipe.sv
// Randomized and directed checks of givens_rot_pipe against an arithmetic reference
// model of the rotation, row coefficient rules and two-deep pipeline occupancy.
module tb_givens_rot_pipe;

    localparam int unsigned DW      = 20;
    localparam int unsigned FRAC    = 16;
    localparam int unsigned ROW_LEN = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_c = '0;
    logic [DW-1:0] in_s = '0;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_x;
    logic [DW-1:0] out_y;
    logic          out_last;

    typedef struct { logic [DW-1:0] c, s, x, y; } pair_t;
    typedef struct { logic [DW-1:0] x, y; logic last; } res_t;

    pair_t  pend[$];
    res_t   exp_q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    int     acc_cnt  = 0;
    int     pop_cnt  = 0;
    int     last_cnt = 0;
    int     idx      = 0;
    longint cc       = 0;
    longint cs       = 0;

    givens_rot_pipe #(.DATA_WIDTH(DW), .FRAC(FRAC), .ROW_LEN(ROW_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_s(in_s), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [DW-1:0] v);
        logic signed [DW-1:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Fixed-point product, truncated toward minus infinity
    function automatic longint fx_mul(input longint a, input longint b);
        return (a * b) >>> FRAC;
    endfunction

    // Reference model and output scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            exp_q.delete();
            idx = 0;
            check_eq("rst_out_valid", 32'(out_valid), 0);
            check_eq("rst_in_ready", 32'(in_ready), 1);
            check_eq("rst_out_x", 32'(out_x), 0);
            check_eq("rst_out_y", 32'(out_y), 0);
            check_eq("rst_out_last", 32'(out_last), 0);
        end else begin
            check_eq("in_ready", 32'(in_ready), (exp_q.size() == 2 && !out_ready) ? 0 : 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", 32'(out_valid), 0);
                end else begin
                    check_eq("out_x", 32'(out_x), 32'(exp_q[0].x));
                    check_eq("out_y", 32'(out_y), 32'(exp_q[0].y));
                    check_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) begin
                        if (out_last) last_cnt++;
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (idx == 0) begin
                    cc = sx(in_c);
                    cs = sx(in_s);
                end
                r.x    = DW'(fx_mul(cc, sx(in_x)) + fx_mul(cs, sx(in_y)));
                r.y    = DW'(fx_mul(cc, sx(in_y)) - fx_mul(cs, sx(in_x)));
                r.last = (idx == int'(ROW_LEN) - 1);
                idx    = (idx + 1) % int'(ROW_LEN);
                exp_q.push_back(r);
                acc_cnt++;
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input bit vld_en, input bit rdy);
        in_valid = vld_en && (pend.size() > 0);
        if (pend.size() > 0) begin
            in_c = pend[0].c;
            in_s = pend[0].s;
            in_x = pend[0].x;
            in_y = pend[0].y;
        end
        out_ready = rdy;
        @(negedge clk);
        if (in_valid && in_ready) void'(pend.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pend.delete();
        rst = 1'b1;
        #1;
        check_eq("reset_kills_valid", 32'(out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("post_rst_valid", 32'(out_valid), 0);
        check_eq("post_rst_ready", 32'(in_ready), 1);
    endtask

    task automatic push(input logic [DW-1:0] c, input logic [DW-1:0] s,
                        input logic [DW-1:0] x, input logic [DW-1:0] y);
        pair_t p;
        p.c = c; p.s = s; p.x = x; p.y = y;
        pend.push_back(p);
    endtask

    task automatic push_rand();
        push(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    endtask

    // Single pair with latency and explicit-value checks
    task automatic directed(input string tag, input logic [DW-1:0] c, input logic [DW-1:0] s,
                            input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic [DW-1:0] ex, input logic [DW-1:0] ey);
        do_reset();
        push(c, s, x, y);
        step(1, 1);
        check_eq({tag, "_lat1_valid"}, 32'(out_valid), 0);
        step(0, 1);
        check_eq({tag, "_lat2_valid"}, 32'(out_valid), 1);
        check_eq({tag, "_x"}, 32'(out_x), 32'(ex));
        check_eq({tag, "_y"}, 32'(out_y), 32'(ey));
        step(0, 1);
    endtask

    initial begin
        int a0;
        int p0;
        int l0;
        int cyc;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("init_valid", 32'(out_valid), 0);
        check_eq("init_ready", 32'(in_ready), 1);

        directed("identity", 20'h10000, 20'h00000, 20'h03000, 20'h05000, 20'h03000, 20'h05000);
        directed("quarter",  20'h00000, 20'h10000, 20'h08000, 20'h04000, 20'h04000, 20'hF8000);
        directed("wrap",     20'h10000, 20'h10000, 20'h40000, 20'h40000, 20'h80000, 20'h00000);

        // Backpressure: three pairs offered against a stalled output
        do_reset();
        repeat (3) push_rand();
        a0 = acc_cnt;
        repeat (4) step(1, 0);
        check_eq("stall_accepts", 32'(acc_cnt - a0), 2);
        check_eq("stall_in_ready", 32'(in_ready), 0);
        check_eq("stall_valid", 32'(out_valid), 1);
        p0 = pop_cnt;
        repeat (3) step(1, 1);
        check_eq("stall_drain_pops", 32'(pop_cnt - p0), 3);
        check_eq("stall_total_accepts", 32'(acc_cnt - a0), 3);

        // Row boundary: nine pairs spanning a row and one element of the next
        do_reset();
        repeat (9) push_rand();
        p0 = pop_cnt;
        l0 = last_cnt;
        repeat (12) step(1, 1);
        check_eq("row_pops", 32'(pop_cnt - p0), 9);
        check_eq("row_lasts", 32'(last_cnt - l0), 1);

        // Reset mid-row, then the next pair must start a fresh row
        do_reset();
        repeat (3) push_rand();
        repeat (3) step(1, 1);
        rst = 1'b1;
        #1;
        check_eq("midrow_rst_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrow_rel_ready", 32'(in_ready), 1);
        check_eq("midrow_rel_valid", 32'(out_valid), 0);
        push(20'h10000, 20'h00000, 20'h01234, 20'h0ABCD);
        p0 = pop_cnt;
        step(1, 1);
        step(0, 1);
        check_eq("midrow_fresh_x", 32'(out_x), 32'h01234);
        check_eq("midrow_fresh_y", 32'(out_y), 32'h0ABCD);
        step(0, 1);
        check_eq("midrow_pops", 32'(pop_cnt - p0), 1);

        // Random traffic with random valid/ready gaps
        do_reset();
        repeat (300) push_rand();
        cyc = 0;
        while (pend.size() > 0 && cyc < 3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            cyc++;
        end
        check_eq("rand_all_sent", 32'(pend.size()), 0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            step(0, 1);
            cyc++;
        end
        check_eq("rand_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
